// File: rtl/controller_mmio_bridge_pkg.sv
// Shared constants for the controller MMIO bridge: register map, board-word bit fields, default debounce mask,
// and the rumble pulse FSM states. No logic, no latency, no flow control.
// Imported by the bridge, its debouncer and the bus interface.
package controller_pkg;

    // Processor-visible register map (2-bit word address, no aliasing)
    localparam logic [1:0] ADDR_STATUS   = 2'd0;
    localparam logic [1:0] ADDR_PRESSED  = 2'd1;
    localparam logic [1:0] ADDR_RELEASED = 2'd2;
    localparam logic [1:0] ADDR_RUMBLE   = 2'd3;

    // Board-input word layout as delivered by the controller manager
    localparam int X_LSB        = 4;
    localparam int X_MSB        = 7;
    localparam int Y_LSB        = 12;
    localparam int Y_MSB        = 15;
    localparam int BTN_LSB      = 16;
    localparam int BTN_MSB      = 19;
    localparam int DPAD_LSB     = 20;
    localparam int DPAD_MSB     = 23;
    localparam int RST_JUMP_LSB = 24;
    localparam int RST_JUMP_MSB = 25;
    localparam int DIR_BIT      = 26;

    // Buttons, D pad, reset and jump are mechanical contacts and get debounced;
    // analog axes and direction come pre-filtered from the manager.
    localparam logic [31:0] DEFAULT_BTN_MASK = 32'h03FF_0000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } rumbleState_t;

endpackage

// File: rtl/controller_mmio_bridge_if.sv
// Processor load/store port of the controller bridge: read/write strobes, word address, data and interrupt.
// Latency: rdData appears one fastClock edge after the rdEn cycle; writes take effect on the strobe edge.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
// Ports: rdEn, wrEn, addr[1:0], wrData[31:0] from the CPU; rdData[31:0], irq back to the CPU.
interface controller_mmio_bridge_if;
    import controller_pkg::*;

    logic        rdEn;
    logic        wrEn;
    logic [1:0]  addr;
    logic [31:0] wrData;
    logic [31:0] rdData;
    logic        irq;

    // CPU side
    modport master (
        output rdEn,
        output wrEn,
        output addr,
        output wrData,
        input  rdData,
        input  irq
    );

    // Bridge side
    modport slave (
        input  rdEn,
        input  wrEn,
        input  addr,
        input  wrData,
        output rdData,
        output irq
    );

endinterface

// File: rtl/controller_mmio_bridge_debounce.sv
// Two-sample debouncer for the synchronized 32-bit board word, stepped by a shared sample tick.
// Latency: a masked bit settles on the second agreeing tick; unmasked bits pass through combinationally.
// Backpressure: none; rise/fall are single-cycle pulses on the edge the stable value changes.
// Ports: fastClock, reset, tick, syncIn[31:0] in; status[31:0], rise[31:0], fall[31:0] out.
module controller_debounce
    import controller_pkg::*;
#(
    parameter logic [31:0] BTN_MASK = DEFAULT_BTN_MASK
) (
    input  logic        fastClock,
    input  logic        reset,
    input  logic        tick,
    input  logic [31:0] syncIn,
    output logic [31:0] status,
    output logic [31:0] rise,
    output logic [31:0] fall
);

    logic [31:0] lastSample;
    logic [31:0] stable;
    logic [31:0] stableNext;
    logic [31:0] agree;

    // A masked bit may move only on a tick where it matches the previous tick's sample.
    // Unmasked bits of 'stable' never change, so rise/fall only ever fire on masked bits.
    always_comb begin
        agree      = '0;
        stableNext = stable;
        if (tick) begin
            agree      = ~(syncIn ^ lastSample) & BTN_MASK;
            stableNext = (stable & ~agree) | (syncIn & agree);
        end
    end

    assign rise   = stableNext & ~stable;
    assign fall   = ~stableNext & stable;
    assign status = (stable & BTN_MASK) | (syncIn & ~BTN_MASK);

    always_ff @(posedge fastClock) begin
        if (reset) begin
            lastSample <= '0;
            stable     <= '0;
        end else begin
            if (tick) begin
                lastSample <= syncIn;
            end
            stable <= stableNext;
        end
    end

endmodule

// File: rtl/controller_mmio_bridge.sv
// CPU-side end of the controller MMIO link: sync + debounce board input, sticky press/release events, rumble pulse.
// Latency: rdData one edge after rdEn; unmasked status 2 cycles, masked status up to 2*DEBOUNCE_DIV+2 cycles.
// Backpressure: none; writes arriving while a rumble pulse is running are dropped.
// Ports: fastClock, reset (sync, active-high), boardInput[31:0] in; boardOutput[31:0] out; cpu bus (slave modport).
// Optional feature: define CTRL_IRQ_EN to enable the irq output and RUMBLE bit 1 (irq mirror).
module controller_mmio_bridge
    import controller_pkg::*;
#(
    parameter int          DEBOUNCE_DIV = 50000,
    parameter int          RUMBLE_PULSE = 4,
    parameter logic [31:0] BTN_MASK     = DEFAULT_BTN_MASK
) (
    input  logic                     fastClock,
    input  logic                     reset,
    input  logic [31:0]              boardInput,
    output logic [31:0]              boardOutput,
    controller_mmio_bridge_if.slave  cpu
);

    localparam int TICK_W  = (DEBOUNCE_DIV > 2) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam int PULSE_W = $clog2(RUMBLE_PULSE + 1);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DEBOUNCE_DIV - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RUMBLE_PULSE - 1);

    // ---------------- input synchronizer ----------------
    logic [31:0] syncA;
    logic [31:0] syncB;

    always_ff @(posedge fastClock) begin
        if (reset) begin
            syncA <= '0;
            syncB <= '0;
        end else begin
            syncA <= boardInput;
            syncB <= syncA;
        end
    end

    // ---------------- shared debounce sample tick ----------------
    logic [TICK_W-1:0] tickCnt;
    logic              sampleTick;

    assign sampleTick = (tickCnt == TICK_LAST);

    always_ff @(posedge fastClock) begin
        if (reset) begin
            tickCnt <= '0;
        end else if (sampleTick) begin
            tickCnt <= '0;
        end else begin
            tickCnt <= tickCnt + 1'b1;
        end
    end

    logic [31:0] statusWord;
    logic [31:0] riseEvt;
    logic [31:0] fallEvt;

    controller_debounce #(
        .BTN_MASK (BTN_MASK)
    ) u_debounce (
        .fastClock (fastClock),
        .reset     (reset),
        .tick      (sampleTick),
        .syncIn    (syncB),
        .status    (statusWord),
        .rise      (riseEvt),
        .fall      (fallEvt)
    );

    // ---------------- sticky event registers ----------------
    logic [31:0] pressed;
    logic [31:0] released;
    logic [31:0] pressedNext;
    logic [31:0] releasedNext;
    logic        clrPressed;
    logic        clrReleased;

    assign clrPressed  = cpu.rdEn && (cpu.addr == ADDR_PRESSED);
    assign clrReleased = cpu.rdEn && (cpu.addr == ADDR_RELEASED);

    // Clear is applied before OR-ing in new events, so an event landing on the
    // clearing edge survives while the read itself returns the pre-edge value.
    assign pressedNext  = (pressed  & ~{32{clrPressed}})  | riseEvt;
    assign releasedNext = (released & ~{32{clrReleased}}) | fallEvt;

    always_ff @(posedge fastClock) begin
        if (reset) begin
            pressed  <= '0;
            released <= '0;
        end else begin
            pressed  <= pressedNext;
            released <= releasedNext;
        end
    end

    // ---------------- rumble pulse FSM ----------------
    rumbleState_t       rumbleState;
    logic [PULSE_W-1:0] pulseCnt;
    logic               pulseOut;
    logic               rumbleReq;
    logic               busy;

    assign rumbleReq = cpu.wrEn && (cpu.addr == ADDR_RUMBLE) && cpu.wrData[0];
    assign busy      = (rumbleState == ST_PULSE);

    always_ff @(posedge fastClock) begin
        if (reset) begin
            rumbleState <= ST_IDLE;
            pulseCnt    <= '0;
            pulseOut    <= 1'b0;
        end else begin
            case (rumbleState)
                ST_IDLE: begin
                    if (rumbleReq) begin
                        rumbleState <= ST_PULSE;
                        pulseCnt    <= PULSE_LAST;
                        pulseOut    <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (pulseCnt == '0) begin
                        rumbleState <= ST_IDLE;
                        pulseOut    <= 1'b0;
                    end else begin
                        pulseCnt <= pulseCnt - 1'b1;
                    end
                end
                default: begin
                    rumbleState <= ST_IDLE;
                    pulseOut    <= 1'b0;
                end
            endcase
        end
    end

    assign boardOutput = {31'b0, pulseOut};

    // Only wrData[0] carries meaning; the rest of the write word is ignored.
    logic unusedWrBits;
    assign unusedWrBits = ^cpu.wrData[31:1];

    // ---------------- interrupt ----------------
    logic irqBit;

`ifdef CTRL_IRQ_EN
    // Tracks |PRESSED with the same edge timing as the register itself.
    logic irqReg;

    always_ff @(posedge fastClock) begin
        if (reset) begin
            irqReg <= 1'b0;
        end else begin
            irqReg <= |pressedNext;
        end
    end

    assign irqBit  = irqReg;
    assign cpu.irq = irqReg;
`else
    assign irqBit  = 1'b0;
    assign cpu.irq = 1'b0;
`endif

    // ---------------- read path ----------------
    logic [31:0] rumbleWord;
    logic [31:0] rdDataQ;

    always_comb begin
        rumbleWord    = '0;
        rumbleWord[0] = busy;
        rumbleWord[1] = irqBit;
    end

    always_ff @(posedge fastClock) begin
        if (reset) begin
            rdDataQ <= '0;
        end else if (cpu.rdEn) begin
            case (cpu.addr)
                ADDR_STATUS:   rdDataQ <= statusWord;
                ADDR_PRESSED:  rdDataQ <= pressed;
                ADDR_RELEASED: rdDataQ <= released;
                default:       rdDataQ <= rumbleWord;
            endcase
        end
    end

    assign cpu.rdData = rdDataQ;

endmodule
